// File: rtl/lnrv_exu_wbck_pkg.sv
// Shared writeback definitions: data width, register-index width and one-hot source-select encoding.
package lnrv_exu_wbck_pkg;

    localparam int XLEN   = 32;
    localparam int RIDX_W = 5;

    typedef logic [2:0] wbck_src_t;

    localparam wbck_src_t WBCK_SRC_ALU = 3'b001;
    localparam wbck_src_t WBCK_SRC_LSU = 3'b010;
    localparam wbck_src_t WBCK_SRC_MDV = 3'b100;

    // x0 is hardwired to zero, so only non-zero indices really write.
    function automatic logic rd_writes(input logic [RIDX_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/lnrv_wbck_arb.sv
// Combinational 3-way fixed-priority arbiter, one-hot grant, zero latency.
// Normal order lsu > mdv > alu; i_alu_first rotates to alu > lsu > mdv.
module lnrv_wbck_arb
    import lnrv_exu_wbck_pkg::*;
(
    input  wbck_src_t i_req,
    input  logic      i_alu_first,
    output wbck_src_t o_gnt
);

    always_comb begin
        o_gnt = '0;
        if (i_alu_first && ((i_req & WBCK_SRC_ALU) != '0)) begin
            o_gnt = WBCK_SRC_ALU;
        end else if ((i_req & WBCK_SRC_LSU) != '0) begin
            o_gnt = WBCK_SRC_LSU;
        end else if ((i_req & WBCK_SRC_MDV) != '0) begin
            o_gnt = WBCK_SRC_MDV;
        end else if ((i_req & WBCK_SRC_ALU) != '0) begin
            o_gnt = WBCK_SRC_ALU;
        end
    end

endmodule

// File: rtl/lnrv_exu_wbck.sv
// GPR writeback arbiter plus one-entry register stage; 1 cycle source handshake to rf_wbck_vld.
// Stage drains and loads in the same cycle; a stalled stage drops every source ready.
module lnrv_exu_wbck #(
    parameter int STARVE_MAX = 4,
    parameter int XLEN       = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,

    input  logic                                  alu_wbck_vld,
    output logic                                  alu_wbck_rdy,
    input  logic [lnrv_exu_wbck_pkg::RIDX_W-1:0]  alu_wbck_rd,
    input  logic [XLEN-1:0]                       alu_wbck_data,

    input  logic                                  lsu_wbck_vld,
    output logic                                  lsu_wbck_rdy,
    input  logic [lnrv_exu_wbck_pkg::RIDX_W-1:0]  lsu_wbck_rd,
    input  logic [XLEN-1:0]                       lsu_wbck_data,

    input  logic                                  mdv_wbck_vld,
    output logic                                  mdv_wbck_rdy,
    input  logic [lnrv_exu_wbck_pkg::RIDX_W-1:0]  mdv_wbck_rd,
    input  logic [XLEN-1:0]                       mdv_wbck_data,

    output logic                                  rf_wbck_vld,
    input  logic                                  rf_wbck_rdy,
    output logic [lnrv_exu_wbck_pkg::RIDX_W-1:0]  rf_wbck_rd,
    output logic [XLEN-1:0]                       rf_wbck_data,
    output logic                                  rf_wbck_wen,

    output logic                                  fwd_vld,
    output logic [lnrv_exu_wbck_pkg::RIDX_W-1:0]  fwd_rd,
    output logic [XLEN-1:0]                       fwd_data
);

    import lnrv_exu_wbck_pkg::*;

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic                r_vld;
    logic                r_wen;
    logic [RIDX_W-1:0]   r_rd;
    logic [XLEN-1:0]     r_data;
    logic [CNT_W-1:0]    r_starve_cnt;

    logic                w_stage_free;
    logic                w_alu_first;
    wbck_src_t           w_req;
    wbck_src_t           w_gnt;
    logic                w_xfer;
    logic [RIDX_W-1:0]   w_sel_rd;
    logic [XLEN-1:0]     w_sel_data;

    assign w_stage_free = ~r_vld | rf_wbck_rdy;
    assign w_alu_first  = (r_starve_cnt == CNT_MAX) & alu_wbck_vld;

    assign w_req = ({3{alu_wbck_vld}} & WBCK_SRC_ALU)
                 | ({3{lsu_wbck_vld}} & WBCK_SRC_LSU)
                 | ({3{mdv_wbck_vld}} & WBCK_SRC_MDV);

    lnrv_wbck_arb u_arb (
        .i_req       (w_req),
        .i_alu_first (w_alu_first),
        .o_gnt       (w_gnt)
    );

    assign alu_wbck_rdy = ((w_gnt & WBCK_SRC_ALU) != '0) & w_stage_free;
    assign lsu_wbck_rdy = ((w_gnt & WBCK_SRC_LSU) != '0) & w_stage_free;
    assign mdv_wbck_rdy = ((w_gnt & WBCK_SRC_MDV) != '0) & w_stage_free;
    assign w_xfer       = alu_wbck_rdy | lsu_wbck_rdy | mdv_wbck_rdy;

    always_comb begin
        w_sel_rd   = alu_wbck_rd;
        w_sel_data = alu_wbck_data;
        if ((w_gnt & WBCK_SRC_LSU) != '0) begin
            w_sel_rd   = lsu_wbck_rd;
            w_sel_data = lsu_wbck_data;
        end else if ((w_gnt & WBCK_SRC_MDV) != '0) begin
            w_sel_rd   = mdv_wbck_rd;
            w_sel_data = mdv_wbck_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_wen  <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
        end else if (w_xfer) begin
            r_vld  <= 1'b1;
            r_wen  <= rd_writes(w_sel_rd);
            r_rd   <= w_sel_rd;
            r_data <= w_sel_data;
        end else if (r_vld && rf_wbck_rdy) begin
            r_vld  <= 1'b0;
            r_wen  <= 1'b0;
        end
    end

    // A stalled stage blocks everyone equally, so it must not count as starvation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!alu_wbck_vld || alu_wbck_rdy) begin
            r_starve_cnt <= '0;
        end else if (w_stage_free && (r_starve_cnt != CNT_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign rf_wbck_vld  = r_vld;
    assign rf_wbck_wen  = r_wen;
    assign rf_wbck_rd   = r_rd;
    assign rf_wbck_data = r_data;

    assign fwd_vld  = r_vld & r_wen;
    assign fwd_rd   = r_rd;
    assign fwd_data = r_data;

endmodule

// File: tb/tb_lnrv_exu_wbck.sv
// Directed bench for lnrv_exu_wbck: arbitration order, starvation override, backpressure, x0, async reset.
module tb_lnrv_exu_wbck;

    logic        clk;
    logic        rst_n;
    logic        alu_wbck_vld, alu_wbck_rdy;
    logic [4:0]  alu_wbck_rd;
    logic [31:0] alu_wbck_data;
    logic        lsu_wbck_vld, lsu_wbck_rdy;
    logic [4:0]  lsu_wbck_rd;
    logic [31:0] lsu_wbck_data;
    logic        mdv_wbck_vld, mdv_wbck_rdy;
    logic [4:0]  mdv_wbck_rd;
    logic [31:0] mdv_wbck_data;
    logic        rf_wbck_vld, rf_wbck_rdy, rf_wbck_wen;
    logic [4:0]  rf_wbck_rd;
    logic [31:0] rf_wbck_data;
    logic        fwd_vld;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int n_cmp = 0;
    int n_err = 0;

    lnrv_exu_wbck #(.STARVE_MAX(4), .XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_wbck_vld  (alu_wbck_vld),
        .alu_wbck_rdy  (alu_wbck_rdy),
        .alu_wbck_rd   (alu_wbck_rd),
        .alu_wbck_data (alu_wbck_data),
        .lsu_wbck_vld  (lsu_wbck_vld),
        .lsu_wbck_rdy  (lsu_wbck_rdy),
        .lsu_wbck_rd   (lsu_wbck_rd),
        .lsu_wbck_data (lsu_wbck_data),
        .mdv_wbck_vld  (mdv_wbck_vld),
        .mdv_wbck_rdy  (mdv_wbck_rdy),
        .mdv_wbck_rd   (mdv_wbck_rd),
        .mdv_wbck_data (mdv_wbck_data),
        .rf_wbck_vld   (rf_wbck_vld),
        .rf_wbck_rdy   (rf_wbck_rdy),
        .rf_wbck_rd    (rf_wbck_rd),
        .rf_wbck_data  (rf_wbck_data),
        .rf_wbck_wen   (rf_wbck_wen),
        .fwd_vld       (fwd_vld),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_wbck_vld = 0; alu_wbck_rd = 0; alu_wbck_data = 0;
        lsu_wbck_vld = 0; lsu_wbck_rd = 0; lsu_wbck_data = 0;
        mdv_wbck_vld = 0; mdv_wbck_rd = 0; mdv_wbck_data = 0;
        rf_wbck_rdy = 1'b1;
        #12;
        n_cmp++; if (rf_wbck_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got=%b exp=0", rf_wbck_vld); end
        n_cmp++; if (rf_wbck_wen !== 1'b0) begin n_err++; $display("FAIL reset_wen got=%b exp=0", rf_wbck_wen); end
        n_cmp++; if (fwd_vld !== 1'b0) begin n_err++; $display("FAIL reset_fwd got=%b exp=0", fwd_vld); end
        n_cmp++; if (rf_wbck_rd !== 5'd0) begin n_err++; $display("FAIL reset_rd got=%0d exp=0", rf_wbck_rd); end
        n_cmp++; if (rf_wbck_data !== 32'd0) begin n_err++; $display("FAIL reset_data got=%h exp=0", rf_wbck_data); end
        n_cmp++; if ({alu_wbck_rdy, lsu_wbck_rdy, mdv_wbck_rdy} !== 3'b000) begin n_err++; $display("FAIL reset_rdy got=%b exp=000", {alu_wbck_rdy, lsu_wbck_rdy, mdv_wbck_rdy}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_alu();
        alu_wbck_vld = 1; alu_wbck_rd = 5'd5; alu_wbck_data = 32'h1234_5678;
        #1;
        n_cmp++; if ({alu_wbck_rdy, lsu_wbck_rdy, mdv_wbck_rdy} !== 3'b100) begin n_err++; $display("FAIL single_rdy got=%b exp=100", {alu_wbck_rdy, lsu_wbck_rdy, mdv_wbck_rdy}); end
        tick();
        alu_wbck_vld = 0;
        n_cmp++; if (rf_wbck_vld !== 1'b1) begin n_err++; $display("FAIL single_vld got=%b exp=1", rf_wbck_vld); end
        n_cmp++; if (rf_wbck_rd !== 5'd5) begin n_err++; $display("FAIL single_rd got=%0d exp=5", rf_wbck_rd); end
        n_cmp++; if (rf_wbck_data !== 32'h1234_5678) begin n_err++; $display("FAIL single_data got=%h exp=12345678", rf_wbck_data); end
        n_cmp++; if (rf_wbck_wen !== 1'b1) begin n_err++; $display("FAIL single_wen got=%b exp=1", rf_wbck_wen); end
        n_cmp++; if ({fwd_vld, fwd_rd, fwd_data} !== {1'b1, 5'd5, 32'h1234_5678}) begin n_err++; $display("FAIL single_fwd got=%b/%0d/%h exp=1/5/12345678", fwd_vld, fwd_rd, fwd_data); end
        tick();
        n_cmp++; if ({rf_wbck_vld, rf_wbck_wen, fwd_vld} !== 3'b000) begin n_err++; $display("FAIL drain_flags got=%b exp=000", {rf_wbck_vld, rf_wbck_wen, fwd_vld}); end
        n_cmp++; if ({rf_wbck_rd, rf_wbck_data} !== {5'd5, 32'h1234_5678}) begin n_err++; $display("FAIL drain_hold got=%0d/%h exp=5/12345678", rf_wbck_rd, rf_wbck_data); end
    endtask

    task automatic test_back_to_back();
        lsu_wbck_vld = 1; lsu_wbck_rd = 5'd3; lsu_wbck_data = 32'hAAAA_0000;
        mdv_wbck_vld = 1; mdv_wbck_rd = 5'd4; mdv_wbck_data = 32'h0000_0055;
        alu_wbck_vld = 1; alu_wbck_rd = 5'd6; alu_wbck_data = 32'h0000_0001;
        #1;
        n_cmp++; if ({alu_wbck_rdy, lsu_wbck_rdy, mdv_wbck_rdy} !== 3'b010) begin n_err++; $display("FAIL b2b_rdy0 got=%b exp=010", {alu_wbck_rdy, lsu_wbck_rdy, mdv_wbck_rdy}); end
        tick();
        lsu_wbck_vld = 0;
        n_cmp++; if ({rf_wbck_vld, rf_wbck_rd, rf_wbck_data} !== {1'b1, 5'd3, 32'hAAAA_0000}) begin n_err++; $display("FAIL b2b_w0 got=%b/%0d/%h exp=1/3/aaaa0000", rf_wbck_vld, rf_wbck_rd, rf_wbck_data); end
        #1;
        n_cmp++; if ({alu_wbck_rdy, lsu_wbck_rdy, mdv_wbck_rdy} !== 3'b001) begin n_err++; $display("FAIL b2b_rdy1 got=%b exp=001", {alu_wbck_rdy, lsu_wbck_rdy, mdv_wbck_rdy}); end
        tick();
        mdv_wbck_vld = 0;
        n_cmp++; if ({rf_wbck_vld, rf_wbck_rd, rf_wbck_data} !== {1'b1, 5'd4, 32'h0000_0055}) begin n_err++; $display("FAIL b2b_w1 got=%b/%0d/%h exp=1/4/00000055", rf_wbck_vld, rf_wbck_rd, rf_wbck_data); end
        #1;
        n_cmp++; if ({alu_wbck_rdy, lsu_wbck_rdy, mdv_wbck_rdy} !== 3'b100) begin n_err++; $display("FAIL b2b_rdy2 got=%b exp=100", {alu_wbck_rdy, lsu_wbck_rdy, mdv_wbck_rdy}); end
        tick();
        alu_wbck_vld = 0;
        n_cmp++; if ({rf_wbck_vld, rf_wbck_rd, rf_wbck_data} !== {1'b1, 5'd6, 32'h0000_0001}) begin n_err++; $display("FAIL b2b_w2 got=%b/%0d/%h exp=1/6/00000001", rf_wbck_vld, rf_wbck_rd, rf_wbck_data); end
        tick();
    endtask

    task automatic test_starvation();
        lsu_wbck_vld = 1; lsu_wbck_rd = 5'd7; lsu_wbck_data = 32'h0000_0777;
        alu_wbck_vld = 1; alu_wbck_rd = 5'd9; alu_wbck_data = 32'h0000_0999;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if ({alu_wbck_rdy, lsu_wbck_rdy} !== 2'b01) begin n_err++; $display("FAIL starve_block%0d got=%b exp=01", i, {alu_wbck_rdy, lsu_wbck_rdy}); end
            tick();
            n_cmp++; if (rf_wbck_rd !== 5'd7) begin n_err++; $display("FAIL starve_lsu%0d got=%0d exp=7", i, rf_wbck_rd); end
        end
        #1;
        n_cmp++; if ({alu_wbck_rdy, lsu_wbck_rdy} !== 2'b10) begin n_err++; $display("FAIL starve_grant got=%b exp=10", {alu_wbck_rdy, lsu_wbck_rdy}); end
        tick();
        n_cmp++; if ({rf_wbck_vld, rf_wbck_rd, rf_wbck_data} !== {1'b1, 5'd9, 32'h0000_0999}) begin n_err++; $display("FAIL starve_alu got=%b/%0d/%h exp=1/9/00000999", rf_wbck_vld, rf_wbck_rd, rf_wbck_data); end
        // A fresh ALU result must wait again: the counter restarted from zero.
        alu_wbck_rd = 5'd10; alu_wbck_data = 32'h0000_0AAA;
        #1;
        n_cmp++; if ({alu_wbck_rdy, lsu_wbck_rdy} !== 2'b01) begin n_err++; $display("FAIL starve_clear got=%b exp=01", {alu_wbck_rdy, lsu_wbck_rdy}); end
        alu_wbck_vld = 0; lsu_wbck_vld = 0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        lsu_wbck_vld = 1; lsu_wbck_rd = 5'd3; lsu_wbck_data = 32'h0000_0011;
        tick();
        rf_wbck_rdy = 0;
        lsu_wbck_rd = 5'd8; lsu_wbck_data = 32'h0000_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (lsu_wbck_rdy !== 1'b0) begin n_err++; $display("FAIL bp_rdy%0d got=%b exp=0", i, lsu_wbck_rdy); end
            tick();
            n_cmp++; if ({rf_wbck_vld, rf_wbck_rd, rf_wbck_data} !== {1'b1, 5'd3, 32'h0000_0011}) begin n_err++; $display("FAIL bp_hold%0d got=%b/%0d/%h exp=1/3/00000011", i, rf_wbck_vld, rf_wbck_rd, rf_wbck_data); end
        end
        rf_wbck_rdy = 1;
        #1;
        n_cmp++; if (lsu_wbck_rdy !== 1'b1) begin n_err++; $display("FAIL bp_release got=%b exp=1", lsu_wbck_rdy); end
        tick();
        lsu_wbck_vld = 0;
        n_cmp++; if ({rf_wbck_vld, rf_wbck_rd, rf_wbck_data} !== {1'b1, 5'd8, 32'h0000_BEEF}) begin n_err++; $display("FAIL bp_load got=%b/%0d/%h exp=1/8/0000beef", rf_wbck_vld, rf_wbck_rd, rf_wbck_data); end
        tick();
        n_cmp++; if (rf_wbck_vld !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%b exp=0", rf_wbck_vld); end
    endtask

    task automatic test_x0_write();
        alu_wbck_vld = 1; alu_wbck_rd = 5'd0; alu_wbck_data = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (alu_wbck_rdy !== 1'b1) begin n_err++; $display("FAIL x0_rdy got=%b exp=1", alu_wbck_rdy); end
        tick();
        alu_wbck_vld = 0;
        n_cmp++; if ({rf_wbck_vld, rf_wbck_wen, fwd_vld} !== 3'b100) begin n_err++; $display("FAIL x0_flags got=%b exp=100", {rf_wbck_vld, rf_wbck_wen, fwd_vld}); end
        n_cmp++; if ({rf_wbck_rd, rf_wbck_data} !== {5'd0, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL x0_payload got=%0d/%h exp=0/ffffffff", rf_wbck_rd, rf_wbck_data); end
        tick();
    endtask

    task automatic test_async_reset();
        alu_wbck_vld = 1; alu_wbck_rd = 5'd10; alu_wbck_data = 32'h0000_CAFE;
        tick();
        alu_wbck_vld = 0;
        rf_wbck_rdy = 0;
        n_cmp++; if ({rf_wbck_vld, rf_wbck_wen, fwd_vld} !== 3'b111) begin n_err++; $display("FAIL arst_pre got=%b exp=111", {rf_wbck_vld, rf_wbck_wen, fwd_vld}); end
        #2;
        rst_n = 0;
        #1;
        n_cmp++; if ({rf_wbck_vld, rf_wbck_wen, fwd_vld} !== 3'b000) begin n_err++; $display("FAIL arst_flags got=%b exp=000", {rf_wbck_vld, rf_wbck_wen, fwd_vld}); end
        n_cmp++; if ({rf_wbck_rd, rf_wbck_data} !== {5'd0, 32'd0}) begin n_err++; $display("FAIL arst_payload got=%0d/%h exp=0/0", rf_wbck_rd, rf_wbck_data); end
        #3;
        rst_n = 1;
        rf_wbck_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (rf_wbck_vld !== 1'b0) begin n_err++; $display("FAIL arst_idle%0d got=%b exp=0", i, rf_wbck_vld); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_alu();
        test_back_to_back();
        test_starvation();
        test_backpressure();
        test_x0_write();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
